alu_result_selector: RTL and testbench

//   Parametrised, registered successor to the ALU one-hot output multiplexer.
//   - Selects one of NCH operation-unit results using a one-hot select from controlLogic.
//   - Buffers the chosen result in a 2-entry output queue with valid/ready handshakes.
//   - Flags illegal (non-one-hot) selects and keeps a saturating error count.
//   - Sits between the ALU operation modules and the result register/consumer.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/onehot_decode.sv | 24 ++
 rtl/alu_result_selector.sv | 137 +++++++++++++
 tb/tb_alu_result_selector.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU constants: datapath geometry and one-hot operation selects
// as driven by controlLogic.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 16;
  localparam int unsigned ALU_NCH   = 12;

  // Bit k of the select picks operation unit k; CLEAR sits on the top bit.
  localparam logic [ALU_NCH-1:0] SEL_AND   = 12'h001;
  localparam logic [ALU_NCH-1:0] SEL_OR    = 12'h002;
  localparam logic [ALU_NCH-1:0] SEL_XOR   = 12'h004;
  localparam logic [ALU_NCH-1:0] SEL_NOT   = 12'h008;
  localparam logic [ALU_NCH-1:0] SEL_ADD   = 12'h010;
  localparam logic [ALU_NCH-1:0] SEL_SUB   = 12'h020;
  localparam logic [ALU_NCH-1:0] SEL_SHL   = 12'h040;
  localparam logic [ALU_NCH-1:0] SEL_SHR   = 12'h080;
  localparam logic [ALU_NCH-1:0] SEL_ROL   = 12'h100;
  localparam logic [ALU_NCH-1:0] SEL_ROR   = 12'h200;
  localparam logic [ALU_NCH-1:0] SEL_CMP   = 12'h400;
  localparam logic [ALU_NCH-1:0] SEL_CLEAR = 12'h800;

endpackage

// File: rtl/onehot_decode.sv
// One-hot select decoder: binary index of the set bit plus a legality flag.
// idx is only meaningful when is_onehot is high.
module onehot_decode #(
  parameter int unsigned NCH  = 12,
  parameter int unsigned IDXW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  sel,
  output logic [IDXW-1:0] idx,
  output logic            is_onehot
);

  // OR-ing the indices of set bits is exact for a one-hot input.
  always_comb begin
    idx = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (sel[k]) begin
        idx = idx | IDXW'(k);
      end
    end
  end

  assign is_onehot = (sel != '0) && ((sel & (sel - NCH'(1))) == '0);

endmodule

// File: rtl/alu_result_selector.sv
// Registered ALU result selector: one-hot channel mux feeding a 2-entry
// valid/ready output queue, with illegal-select flagging and error counting.
module alu_result_selector
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH     = ALU_WIDTH,
  parameter int unsigned NCH       = ALU_NCH,
  parameter int unsigned CLEAR_IDX = ALU_NCH - 1,
  parameter int unsigned ERRW      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NCH*WIDTH-1:0] ch_data,
  input  logic [NCH-1:0]     sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   res,
  output logic               res_zero,
  output logic               sel_err,
  output logic [ERRW-1:0]    err_count,
  input  logic               clr_err
);

  localparam int unsigned     IDXW     = $clog2(NCH);
  localparam logic [IDXW-1:0] ClearIdx = IDXW'(CLEAR_IDX);
  localparam logic [ERRW-1:0] ErrMax   = '1;

  // Decode and channel mux
  logic [IDXW-1:0]  dec_idx;
  logic             dec_onehot;
  logic [WIDTH-1:0] mux_data;
  logic [WIDTH-1:0] push_data;
  logic             push_err;

  onehot_decode #(
    .NCH  (NCH),
    .IDXW (IDXW)
  ) u_decode (
    .sel       (sel),
    .idx       (dec_idx),
    .is_onehot (dec_onehot)
  );

  always_comb begin
    mux_data = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (dec_idx == IDXW'(k)) begin
        mux_data = ch_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // CLEAR and illegal selects both store zero; only illegal ones flag an error.
  assign push_data = (dec_onehot && (dec_idx != ClearIdx)) ? mux_data : '0;
  assign push_err  = ~dec_onehot;

  // Queue state
  logic [WIDTH-1:0] data_q [2];
  logic             err_q  [2];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             in_ready_q, in_ready_d;
  logic [WIDTH-1:0] last_data_q, last_data_d;
  logic             last_err_q, last_err_d;
  logic [ERRW-1:0]  err_cnt_q, err_cnt_d;
  logic             push, pop;

  assign out_valid = (count_q != 2'd0);
  assign in_ready  = in_ready_q;
  assign push      = in_valid & in_ready_q;
  assign pop       = out_valid & out_ready;

  always_comb begin
    count_d     = count_q + {1'b0, push} - {1'b0, pop};
    in_ready_d  = (count_d < 2'd2);
    rd_ptr_d    = rd_ptr_q ^ pop;
    wr_ptr_d    = wr_ptr_q ^ push;
    last_data_d = last_data_q;
    last_err_d  = last_err_q;
    // Remember the departing head so outputs hold their last value when empty.
    if (pop) begin
      last_data_d = data_q[rd_ptr_q];
      last_err_d  = err_q[rd_ptr_q];
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clr_err) begin
      err_cnt_d = (push && push_err) ? ERRW'(1) : '0;
    end else if (push && push_err && (err_cnt_q != ErrMax)) begin
      err_cnt_d = err_cnt_q + ERRW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      in_ready_q  <= 1'b1;
      last_data_q <= '0;
      last_err_q  <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      last_data_q <= last_data_d;
      last_err_q  <= last_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      err_q[0]  <= 1'b0;
      err_q[1]  <= 1'b0;
    end else if (push) begin
      data_q[wr_ptr_q] <= push_data;
      err_q[wr_ptr_q]  <= push_err;
    end
  end

  // Outputs
  assign res       = out_valid ? data_q[rd_ptr_q] : last_data_q;
  assign sel_err   = out_valid ? err_q[rd_ptr_q]  : last_err_q;
  assign res_zero  = (res == '0);
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_alu_result_selector.sv
// Scoreboard bench for alu_result_selector: the driver queues expected beats,
// a negedge monitor pops and compares every accepted output beat.
module tb_alu_result_selector;
  import alu_pkg::*;

  localparam int W = 16;
  localparam int N = 12;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [N*W-1:0] ch_data = '0;
  logic [N-1:0]   sel = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   res;
  logic           res_zero;
  logic           sel_err;
  logic [1:0]     err_count;
  logic           clr_err = 1'b0;

  int checks = 0;
  int errors = 0;
  int nbeat  = 0;
  logic [W+1:0] exp_q [$];

  alu_result_selector #(
    .WIDTH     (W),
    .NCH       (N),
    .CLEAR_IDX (11),
    .ERRW      (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ch_data   (ch_data),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .res_zero  (res_zero),
    .sel_err   (sel_err),
    .err_count (err_count),
    .clr_err   (clr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [N*W-1:0] fill(input logic [W-1:0] v);
    logic [N*W-1:0] r;
    for (int k = 0; k < N; k++) r[k*W +: W] = v;
    return r;
  endfunction

  // Offer one beat, queue its hand-computed expectation once it is accepted.
  task automatic send(input logic [N-1:0] s, input logic [N*W-1:0] cd,
                      input logic [W-1:0] ed, input logic ee);
    int n = 0;
    in_valid = 1'b1;
    sel      = s;
    ch_data  = cd;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n >= 100) break;
    end
    if (in_ready) begin
      exp_q.push_back({ee, (ed == '0), ed});
    end else begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready got 0 expected 1 within 100 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor
  initial begin
    logic [W+1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        nbeat++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got res=%h err=%b expected no beat", res, sel_err);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("beat%0d", nbeat), {14'd0, sel_err, res_zero, res}, {14'd0, e});
        end
      end
    end
  end

  initial begin
    logic [N*W-1:0] cd;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_res", res, 0);
    check("rst_res_zero", res_zero, 1);
    check("rst_sel_err", sel_err, 0);
    check("rst_err_count", err_count, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: AND channel, one-cycle latency
    out_ready = 1'b1;
    cd = '0;
    cd[0*W +: W] = 16'h00F0;
    send(SEL_AND, cd, 16'h00F0, 1'b0);
    check("t1_out_valid", out_valid, 1);
    check("t1_res", res, 16'h00F0);

    // Mid channel with other channels populated
    cd = fill(16'h5A5A);
    cd[0*W +: W] = 16'h1234;
    cd[5*W +: W] = 16'hABCD;
    send(SEL_SUB, cd, 16'hABCD, 1'b0);

    // 2: CLEAR forces zero without error
    send(SEL_CLEAR, fill(16'hFFFF), 16'h0000, 1'b0);
    check("t2_err_count", err_count, 0);

    // 3: multi-bit and empty selects
    send(12'h003, fill(16'hFFFF), 16'h0000, 1'b1);
    send(12'h000, fill(16'hFFFF), 16'h0000, 1'b1);
    check("t3_err_count", err_count, 2);
    wait_drain();

    // 4: fill the queue while stalled, third beat held off
    out_ready = 1'b0;
    send(SEL_AND, fill(16'h1111), 16'h1111, 1'b0);
    send(SEL_AND, fill(16'h2222), 16'h2222, 1'b0);
    fork
      send(SEL_AND, fill(16'h3333), 16'h3333, 1'b0);
    join_none
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_in_ready_full", in_ready, 0);
      check("t4_res_stall", res, 16'h1111);
      check("t4_out_valid_stall", out_valid, 1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain();
    check("t4_empty_valid", out_valid, 0);
    check("t4_hold_res", res, 16'h3333);

    // 5: saturation and clear
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
    check("t5_clear", err_count, 0);
    for (int i = 0; i < 5; i++) begin
      send((i % 2 == 0) ? 12'h000 : 12'h081, fill(16'h7777), 16'h0000, 1'b1);
    end
    check("t5_saturate", err_count, 3);
    clr_err = 1'b1;
    send(12'h0C0, fill(16'h7777), 16'h0000, 1'b1);
    clr_err = 1'b0;
    check("t5_clear_and_err", err_count, 1);
    wait_drain();

    // 6: asynchronous reset with two beats queued
    out_ready = 1'b0;
    send(SEL_OR, fill(16'hBEEF), 16'hBEEF, 1'b0);
    send(SEL_XOR, fill(16'hCAFE), 16'hCAFE, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("t6_out_valid", out_valid, 0);
    check("t6_in_ready", in_ready, 1);
    check("t6_err_count", err_count, 0);
    check("t6_res", res, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t6_no_stale", out_valid, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
